// File: rtl/spi_status_tx.sv
// rtl/spi_status_tx.sv - SPI mode-0 status word transmitter, oversampled in the system clock domain
module spi_status_tx #(
    parameter int N_BYTES = 4,
    localparam int W = 8 * N_BYTES
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sck,
    input  logic         ce,
    input  logic [W-1:0] status_word,
    output logic         sdo,
    output logic         busy,
    output logic         frame_done,
    output logic         frame_abort
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // [0],[1] synchronize, [2] is the delayed copy for edge detection
    logic [2:0]    sck_sync_q;
    logic [2:0]    ce_sync_q;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          abort_q, abort_d;

    logic          sck_fall;
    logic          ce_rise;
    logic          ce_fall;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sck_sync_q <= '0;
            ce_sync_q  <= '0;
        end else begin
            sck_sync_q <= {sck_sync_q[1:0], sck};
            ce_sync_q  <= {ce_sync_q[1:0], ce};
        end
    end

    assign sck_fall = sck_sync_q[2] & ~sck_sync_q[1];
    assign ce_rise  = ce_sync_q[1] & ~ce_sync_q[2];
    assign ce_fall  = ce_sync_q[2] & ~ce_sync_q[1];

    // After W left shifts of zeros the register is empty, so sdo drops to 0 in DONE on its own.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ce_rise) begin
                    shift_d = status_word;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (ce_fall) begin
                    abort_d = 1'b1;
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (sck_fall) begin
                    shift_d = {shift_q[W-2:0], 1'b0};
                    if (cnt_q == LAST_BIT) begin
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DONE: begin
                if (ce_fall) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                shift_d = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign sdo         = shift_q[W-1];
    assign busy        = (state_q != S_IDLE);
    assign frame_done  = done_q;
    assign frame_abort = abort_q;

endmodule
